// File: rtl/pc_fetch_if.sv
// Bundle of the fetch-unit control inputs and the fetch-request / RAS status
// outputs. The decode/ALU redirect side uses the master modport; the fetch
// unit itself uses the slave modport.
interface pc_fetch_if #(
  parameter int ADDR_W = 11
);
  logic              pc_en;
  logic              fetch_ready;
  logic [1:0]        pc_sel;
  logic [ADDR_W-1:0] imm_addr;
  logic [ADDR_W-1:0] alu_addr;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_underflow;
  logic              misalign_err;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    output pc_en, fetch_ready, pc_sel, imm_addr, alu_addr, call, ret,
    input  pc, pc_valid, ras_empty, ras_full, ras_underflow, misalign_err, err_addr
  );

  modport slave (
    input  pc_en, fetch_ready, pc_sel, imm_addr, alu_addr, call, ret,
    output pc, pc_valid, ras_empty, ras_full, ras_underflow, misalign_err, err_addr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: holds the fetch PC, selects the next PC from
// sequential / immediate / ALU / hold sources or from a circular return-address
// stack, handshakes with instruction memory and flags misaligned targets.
// Every output comes straight from a register.
module pc_fetch_unit #(
  parameter int                ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  pc_fetch_if.slave bus
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(3'd4);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);

  // Word alignment: the two low address bits must be clear.
  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    is_aligned = (addr[1:0] == 2'b00);
  endfunction

  // Architectural state
  logic [ADDR_W-1:0] pc_r;
  logic              pc_valid_r;
  logic              ras_empty_r;
  logic              ras_full_r;
  logic              ras_underflow_r;
  logic              misalign_err_r;
  logic [ADDR_W-1:0] err_addr_r;
  logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]  top_r;
  logic [CNT_W-1:0]  count_r;

  // Next-state helpers
  logic              adv_s;
  logic [ADDR_W-1:0] pc_plus4_s;
  logic              ras_nonempty_s;
  logic [ADDR_W-1:0] target_s;
  logic              underflow_s;
  logic              aligned_s;
  logic              take_s;
  logic              redirect_s;
  logic              push_s;
  logic              pop_s;
  logic              replace_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [PTR_W-1:0]  top_nxt_s;
  logic              wr_en_s;
  logic [PTR_W-1:0]  wr_idx_s;

  // Advance qualifier and next-PC target selection (RAS return has priority over pc_sel)
  always_comb begin
    adv_s          = pc_valid_r & bus.pc_en & bus.fetch_ready;
    pc_plus4_s     = pc_r + PC_STEP;
    ras_nonempty_s = (count_r != '0);
    target_s       = pc_r;
    underflow_s    = 1'b0;
    if (bus.ret) begin
      if (ras_nonempty_s) begin
        target_s = ras_mem_r[top_r];
      end else begin
        // Nothing to return to: fall back on the computed jalr target.
        target_s    = bus.alu_addr;
        underflow_s = 1'b1;
      end
    end else begin
      case (bus.pc_sel)
        2'b00:   target_s = pc_plus4_s;
        2'b01:   target_s = bus.imm_addr;
        2'b10:   target_s = bus.alu_addr;
        2'b11:   target_s = pc_r;
        default: target_s = pc_r;
      endcase
    end
    aligned_s = is_aligned(target_s);
  end

  // RAS bookkeeping: decide push / pop / top-replace and the next pointer and count
  always_comb begin
    take_s      = adv_s & aligned_s;
    redirect_s  = (bus.pc_sel == 2'b01) | (bus.pc_sel == 2'b10);
    // A call+ret pair with an empty stack degenerates into a plain push.
    push_s      = take_s & bus.call &
                  ((redirect_s & ~bus.ret) | (bus.ret & ~ras_nonempty_s));
    pop_s       = take_s & bus.ret & ras_nonempty_s & ~bus.call;
    replace_s   = take_s & bus.ret & ras_nonempty_s & bus.call;
    count_nxt_s = count_r;
    top_nxt_s   = top_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = top_r;
    if (push_s) begin
      // The pointer wraps, so a push onto a full stack lands on the oldest entry.
      top_nxt_s = top_r + PTR_ONE;
      wr_en_s   = 1'b1;
      wr_idx_s  = top_r + PTR_ONE;
      if (count_r == CNT_FULL) begin
        count_nxt_s = count_r;
      end else begin
        count_nxt_s = count_r + CNT_ONE;
      end
    end else if (pop_s) begin
      top_nxt_s   = top_r - PTR_ONE;
      count_nxt_s = count_r - CNT_ONE;
    end else if (replace_s) begin
      wr_en_s  = 1'b1;
      wr_idx_s = top_r;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Fetch PC, request valid, and the registered error pulses / captured address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r            <= RESET_VEC;
      pc_valid_r      <= 1'b0;
      ras_underflow_r <= 1'b0;
      misalign_err_r  <= 1'b0;
      err_addr_r      <= '0;
    end else begin
      // The first edge out of reset only raises the request; pc moves afterwards.
      pc_valid_r      <= 1'b1;
      ras_underflow_r <= adv_s & underflow_s;
      misalign_err_r  <= adv_s & ~aligned_s;
      if (take_s) begin
        pc_r <= target_s;
      end
      if (adv_s & ~aligned_s) begin
        err_addr_r <= target_s;
      end
    end
  end

  // RAS top pointer, occupancy count and registered empty/full flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_r       <= '0;
      count_r     <= '0;
      ras_empty_r <= 1'b1;
      ras_full_r  <= 1'b0;
    end else begin
      top_r       <= top_nxt_s;
      count_r     <= count_nxt_s;
      ras_empty_r <= (count_nxt_s == '0);
      ras_full_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // RAS entry storage; contents are meaningless until pushed, so no reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ras_mem_r[wr_idx_s] <= pc_plus4_s;
    end
  end

  assign bus.pc            = pc_r;
  assign bus.pc_valid      = pc_valid_r;
  assign bus.ras_empty     = ras_empty_r;
  assign bus.ras_full      = ras_full_r;
  assign bus.ras_underflow = ras_underflow_r;
  assign bus.misalign_err  = misalign_err_r;
  assign bus.err_addr      = err_addr_r;

endmodule
